block_move_arbiter: RTL and testbench

//  Owns the on-screen block position (xpos/ypos centre) and shares it between two

---
 rtl/block_move_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_block_move_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/block_move_arbiter.sv
// ---------------------------------------------------------------------------
// block_move_arbiter
//
// Purpose:
//   Owns the on-screen block centre position and shares it between two
//   movement requesters (0 = board buttons, 1 = keyboard/UART decoder).
//   Once per frame tick the requests are sampled, one requester is granted
//   using a round-robin pointer, and a single STEP move with screen wrap is
//   applied.  The pixel/colour logic only reads xpos_o, ypos_o, last_dir_o.
//
// Ports:
//   clk           in   1   system clock
//   rst           in   1   reset, asynchronous, active-high
//   frame_tick_i  in   1   one-cycle pulse, once per video frame
//   req0_i        in   4   requester 0 direction {up,down,left,right}
//   req1_i        in   4   requester 1 direction {up,down,left,right}
//   xpos_o        out 10   block centre x
//   ypos_o        out 10   block centre y
//   grant_o       out  2   one-hot winner of last arbitration, 00 = none
//   move_valid_o  out  1   one-cycle pulse: xpos_o/ypos_o just updated
//   last_dir_o    out  4   one-hot direction of most recent applied move
//
// Configuration macro:
//   STICKY_GRANT_EN  defined   -> winner keeps ownership while it requests
//                    undefined -> pointer moves to the other requester
//                                 after every grant (strict alternation)
//
// Timing: frame_tick_i sampled in IDLE -> ARB -> MOVE; the new position and
// move_valid_o are visible three cycles after the tick cycle.
// ---------------------------------------------------------------------------
module block_move_arbiter #(
    parameter int unsigned STEP  = 2,
    parameter int unsigned X_MIN = 150,
    parameter int unsigned X_MAX = 800,
    parameter int unsigned Y_MIN = 34,
    parameter int unsigned Y_MAX = 514,
    parameter int unsigned X_RST = 450,
    parameter int unsigned Y_RST = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick_i,
    input  logic [3:0] req0_i,
    input  logic [3:0] req1_i,
    output logic [9:0] xpos_o,
    output logic [9:0] ypos_o,
    output logic [1:0] grant_o,
    output logic       move_valid_o,
    output logic [3:0] last_dir_o
);

    // Wrap comparisons are done in 11 bits so xpos+STEP cannot overflow.
    localparam logic [10:0] STEP_W  = 11'(STEP);
    localparam logic [10:0] X_MIN_W = 11'(X_MIN);
    localparam logic [10:0] X_MAX_W = 11'(X_MAX);
    localparam logic [10:0] Y_MIN_W = 11'(Y_MIN);
    localparam logic [10:0] Y_MAX_W = 11'(Y_MAX);
    localparam logic [9:0]  STEP_N  = 10'(STEP);
    localparam logic [9:0]  X_RST_N = 10'(X_RST);
    localparam logic [9:0]  Y_RST_N = 10'(Y_RST);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        MOVE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  s0_q, s0_d;      // sampled requester 0
    logic [3:0]  s1_q, s1_d;      // sampled requester 1
    logic [9:0]  x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic [1:0]  grant_q, grant_d;
    logic        mv_q, mv_d;
    logic [3:0]  dir_q, dir_d;
    logic        rr_q, rr_d;      // favoured requester index

    logic        win1;
    logic [3:0]  win_req;
    logic [3:0]  dir_sel;
    logic [10:0] x_inc;
    logic [10:0] y_inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            s0_q    <= 4'b0000;
            s1_q    <= 4'b0000;
            x_q     <= X_RST_N;
            y_q     <= Y_RST_N;
            grant_q <= 2'b00;
            mv_q    <= 1'b0;
            dir_q   <= 4'b0000;
            rr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            x_q     <= x_d;
            y_q     <= y_d;
            grant_q <= grant_d;
            mv_q    <= mv_d;
            dir_q   <= dir_d;
            rr_q    <= rr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s0_d    = s0_q;
        s1_d    = s1_q;
        x_d     = x_q;
        y_d     = y_q;
        grant_d = grant_q;
        mv_d    = 1'b0;
        dir_d   = dir_q;
        rr_d    = rr_q;

        // Favoured requester wins when it has a request, else the other one.
        win1 = rr_q ? (s1_q != 4'b0000) : (s0_q == 4'b0000);

        // In MOVE, grant_q already names the winner.
        win_req = grant_q[1] ? s1_q : s0_q;

        // Direction priority: right > left > up > down.
        dir_sel = 4'b0000;
        if (win_req[0])      dir_sel = 4'b0001;
        else if (win_req[1]) dir_sel = 4'b0010;
        else if (win_req[3]) dir_sel = 4'b1000;
        else if (win_req[2]) dir_sel = 4'b0100;

        x_inc = {1'b0, x_q} + STEP_W;
        y_inc = {1'b0, y_q} + STEP_W;

        case (state_q)
            IDLE: begin
                if (frame_tick_i) begin
                    s0_d    = req0_i;
                    s1_d    = req1_i;
                    state_d = ARB;
                end
            end
            ARB: begin
                if ((s0_q == 4'b0000) && (s1_q == 4'b0000)) begin
                    grant_d = 2'b00;
                    state_d = IDLE;
                end else begin
                    grant_d = win1 ? 2'b10 : 2'b01;
                    state_d = MOVE;
                end
            end
            MOVE: begin
                if (dir_sel[0]) begin
                    x_d = (x_inc > X_MAX_W) ? X_MIN_W[9:0] : x_inc[9:0];
                end else if (dir_sel[1]) begin
                    x_d = ({1'b0, x_q} < (X_MIN_W + STEP_W)) ? X_MAX_W[9:0] : (x_q - STEP_N);
                end else if (dir_sel[3]) begin
                    y_d = ({1'b0, y_q} < (Y_MIN_W + STEP_W)) ? Y_MAX_W[9:0] : (y_q - STEP_N);
                end else if (dir_sel[2]) begin
                    y_d = (y_inc > Y_MAX_W) ? Y_MIN_W[9:0] : y_inc[9:0];
                end
                dir_d = dir_sel;
                mv_d  = 1'b1;
`ifdef STICKY_GRANT_EN
                rr_d  = grant_q[1];
`else
                rr_d  = ~grant_q[1];
`endif
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign xpos_o       = x_q;
    assign ypos_o       = y_q;
    assign grant_o      = grant_q;
    assign move_valid_o = mv_q;
    assign last_dir_o   = dir_q;

endmodule

// File: tb/tb_block_move_arbiter.sv
// ---------------------------------------------------------------------------
// tb_block_move_arbiter
//
// Directed bench for block_move_arbiter.  A small behavioural model predicts
// each frame's outcome; predicted moves are pushed to a scoreboard queue when
// the frame tick is driven and popped when move_valid_o appears.
// ---------------------------------------------------------------------------
module tb_block_move_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_tick_i;
    logic [3:0] req0_i;
    logic [3:0] req1_i;
    logic [9:0] xpos_o;
    logic [9:0] ypos_o;
    logic [1:0] grant_o;
    logic       move_valid_o;
    logic [3:0] last_dir_o;

    always #5 clk = ~clk;

    block_move_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .frame_tick_i (frame_tick_i),
        .req0_i       (req0_i),
        .req1_i       (req1_i),
        .xpos_o       (xpos_o),
        .ypos_o       (ypos_o),
        .grant_o      (grant_o),
        .move_valid_o (move_valid_o),
        .last_dir_o   (last_dir_o)
    );

    typedef struct {
        int         x;
        int         y;
        logic [1:0] g;
        logic [3:0] d;
    } exp_t;

    exp_t sb[$];

    int vectors     = 0;
    int miscompares = 0;

    // behavioural model state
    int         mx;
    int         my;
    int         mrr;
    logic [3:0] md;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_xpos",  32'(xpos_o), 32'd450);
        chk("rst_ypos",  32'(ypos_o), 32'd250);
        chk("rst_grant", 32'(grant_o), 32'd0);
        chk("rst_mv",    32'(move_valid_o), 32'd0);
        chk("rst_dir",   32'(last_dir_o), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        mx = 450; my = 250; mrr = 0; md = 4'b0000;
        sb.delete();
    endtask

    // One frame: predict, drive tick, wait (bounded) for the move, compare.
    task automatic frame(input logic [3:0] r0, input logic [3:0] r1, input bit dbl);
        exp_t       e;
        exp_t       got;
        bit         mv;
        int         w;
        int         c;
        int         extra;
        logic [3:0] r;
        logic [3:0] d;

        mv = (r0 != 4'b0000) || (r1 != 4'b0000);
        if (mv) begin
            if (mrr == 0) w = (r0 != 4'b0000) ? 0 : 1;
            else          w = (r1 != 4'b0000) ? 1 : 0;
            r = (w == 1) ? r1 : r0;
            if (r[0]) begin
                d = 4'b0001; mx = (mx + 2 > 800) ? 150 : mx + 2;
            end else if (r[1]) begin
                d = 4'b0010; mx = (mx < 152) ? 800 : mx - 2;
            end else if (r[3]) begin
                d = 4'b1000; my = (my < 36) ? 514 : my - 2;
            end else begin
                d = 4'b0100; my = (my + 2 > 514) ? 34 : my + 2;
            end
            md = d;
`ifdef STICKY_GRANT_EN
            mrr = w;
`else
            mrr = 1 - w;
`endif
            e.x = mx; e.y = my; e.g = (w == 1) ? 2'b10 : 2'b01; e.d = d;
            sb.push_back(e);
        end

        req0_i = r0;
        req1_i = r1;
        frame_tick_i = 1'b1;
        c = 0;
        while (1) begin
            @(posedge clk);
            #1;
            c++;
            if (c == 1) begin
                // Changing requests after sampling must not matter.
                req0_i = ~r0;
                req1_i = ~r1;
                if (!dbl) frame_tick_i = 1'b0;
            end
            if (c == 2) frame_tick_i = 1'b0;
            if (move_valid_o || c >= 8) break;
        end

        if (mv) begin
            chk("latency", 32'(c), 32'd3);
            if (move_valid_o && sb.size() > 0) begin
                got = sb.pop_front();
                chk("xpos",     32'(xpos_o), 32'(got.x));
                chk("ypos",     32'(ypos_o), 32'(got.y));
                chk("grant",    32'(grant_o), 32'(got.g));
                chk("last_dir", 32'(last_dir_o), 32'(got.d));
            end else begin
                chk("move_timeout", 32'(move_valid_o), 32'd1);
                if (sb.size() > 0) void'(sb.pop_front());
            end
        end else begin
            chk("nomove_pulse", 32'(move_valid_o), 32'd0);
            chk("nomove_grant", 32'(grant_o), 32'd0);
            chk("nomove_xpos",  32'(xpos_o), 32'(mx));
            chk("nomove_ypos",  32'(ypos_o), 32'(my));
            chk("nomove_dir",   32'(last_dir_o), 32'(md));
        end

        extra = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (move_valid_o) extra++;
        end
        chk("extra_pulses", 32'(extra), 32'd0);
        req0_i = 4'b0000;
        req1_i = 4'b0000;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] ex_x [4];
        logic [1:0] ex_g [4];
        int         pulses;

        rst = 1'b0;
        frame_tick_i = 1'b0;
        req0_i = 4'b0000;
        req1_i = 4'b0000;
        mx = 450; my = 250; mrr = 0; md = 4'b0000;
        @(posedge clk);
        #1;

        // reset state
        do_reset();

        // single right move
        frame(4'b0001, 4'b0000, 1'b0);
        chk("t2_xpos", 32'(xpos_o), 32'd452);
        chk("t2_dir",  32'(last_dir_o), 32'd1);

        // contention: req0 right, req1 left
        do_reset();
`ifdef STICKY_GRANT_EN
        ex_x[0] = 10'd452; ex_x[1] = 10'd454; ex_x[2] = 10'd456; ex_x[3] = 10'd458;
        ex_g[0] = 2'b01;   ex_g[1] = 2'b01;   ex_g[2] = 2'b01;   ex_g[3] = 2'b01;
`else
        ex_x[0] = 10'd452; ex_x[1] = 10'd450; ex_x[2] = 10'd452; ex_x[3] = 10'd450;
        ex_g[0] = 2'b01;   ex_g[1] = 2'b10;   ex_g[2] = 2'b01;   ex_g[3] = 2'b10;
`endif
        for (int i = 0; i < 4; i++) begin
            frame(4'b0001, 4'b0010, 1'b0);
            chk($sformatf("t3_xpos%0d", i),  32'(xpos_o), 32'(ex_x[i]));
            chk($sformatf("t3_grant%0d", i), 32'(grant_o), 32'(ex_g[i]));
        end

        // idle frame: nothing requested
        frame(4'b0000, 4'b0000, 1'b0);

        // all directions at once plus a second tick during ARB
        do_reset();
        frame(4'b1111, 4'b0000, 1'b1);
        chk("t5_xpos", 32'(xpos_o), 32'd452);
        chk("t5_ypos", 32'(ypos_o), 32'd250);
        chk("t5_dir",  32'(last_dir_o), 32'd1);

        // requester 1 alone, down
        frame(4'b0000, 4'b0100, 1'b0);
        chk("r1_ypos", 32'(ypos_o), 32'd252);

        // wraps
        do_reset();
        while (mx != 800) frame(4'b0001, 4'b0000, 1'b0);
        chk("at_xmax", 32'(xpos_o), 32'd800);
        frame(4'b0001, 4'b0000, 1'b0);
        chk("wrap_right", 32'(xpos_o), 32'd150);
        frame(4'b0010, 4'b0000, 1'b0);
        chk("wrap_left", 32'(xpos_o), 32'd800);
        while (my != 34) frame(4'b1000, 4'b0000, 1'b0);
        chk("at_ymin", 32'(ypos_o), 32'd34);
        frame(4'b1000, 4'b0000, 1'b0);
        chk("wrap_up", 32'(ypos_o), 32'd514);
        frame(4'b0100, 4'b0000, 1'b0);
        chk("wrap_down", 32'(ypos_o), 32'd34);

        // reset while in ARB
        do_reset();
        req0_i = 4'b0001;
        frame_tick_i = 1'b1;
        @(posedge clk);
        #1 frame_tick_i = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("t6_xpos_in_rst",  32'(xpos_o), 32'd450);
        chk("t6_grant_in_rst", 32'(grant_o), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        req0_i = 4'b0000;
        mx = 450; my = 250; mrr = 0; md = 4'b0000;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (move_valid_o) pulses++;
        end
        chk("t6_pulses", 32'(pulses), 32'd0);
        chk("t6_xpos",   32'(xpos_o), 32'd450);
        chk("t6_grant",  32'(grant_o), 32'd0);
        frame(4'b0001, 4'b0000, 1'b0);
        chk("t6_after_xpos", 32'(xpos_o), 32'd452);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
